// File: rtl/spi_mem_responder_pkg.sv
// spi_mem_responder_pkg: SPI SRAM command bytes and bus FSM state encodings.
package spi_mem_responder_pkg;
  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/spi_mem_responder_if.sv
// spi_mem_responder_if: cpu bus between a master (cpu) and the SPI memory responder.
interface spi_mem_responder_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_read;
  logic        bus_write;
  logic        bus_wait;
  modport master (output bus_address_in, bus_data_in, bus_read, bus_write, input bus_data_out, bus_wait);
  modport slave  (input bus_address_in, bus_data_in, bus_read, bus_write, output bus_data_out, bus_wait);
endinterface

// File: rtl/spi_mem_responder_bit_engine.sv
// spi_mem_responder_bit_engine: SPI mode-0 frame shifter with SCK divider, MSB first.
module spi_mem_responder_bit_engine #(
  parameter int CLK_DIV = 2,
  parameter int NBITS   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_tx,
  input  logic             i_miso,
  output logic             o_sck,
  output logic             o_mosi,
  output logic             o_done,
  output logic [7:0]       o_rx
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS);
  logic             r_busy;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bit;
  logic [NBITS-1:0] r_sh;
  logic             w_tick;
  assign w_tick = r_busy & (r_div == DW'(CLK_DIV - 1));
  // done is combinational so the bus FSM leaves SHIFT on the very edge SCK falls after the last bit
  assign o_done = w_tick & o_sck & (r_bit == BW'(NBITS - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_div  <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
      o_sck  <= 1'b0;
      o_mosi <= 1'b0;
      o_rx   <= 8'h00;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= '0;
      r_bit  <= '0;
      r_sh   <= {i_tx[NBITS-2:0], 1'b0};
      o_sck  <= 1'b0;
      o_mosi <= i_tx[NBITS-1];
    end else if (r_busy) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        o_sck <= ~o_sck;
        if (!o_sck) o_rx <= {o_rx[6:0], i_miso};
        else if (o_done) r_busy <= 1'b0;
        else begin
          r_bit  <= r_bit + 1'b1;
          r_sh   <= r_sh << 1;
          o_mosi <= r_sh[NBITS-1];
        end
      end
    end
  end
endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: cpu bus target backed by a 23LC512-style SPI SRAM.
// Optional one-entry read cache enabled by defining SPI_RESP_CACHE_EN.
module spi_mem_responder
  import spi_mem_responder_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_mem_responder_if.slave  bus,
  output logic                spi_cs_n,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
);
  localparam int NBITS = 8 * (ADDR_BYTES + 2);
  state_t           r_state;
  logic             r_ack;
  logic             r_wr;
  logic [7:0]       r_rdata;
  logic             w_req;
  logic             w_hit;
  logic             w_start;
  logic             w_done;
  logic [7:0]       w_rx;
  logic [NBITS-1:0] w_frame;
  assign w_req            = bus.bus_read | bus.bus_write;
  assign bus.bus_wait     = w_req & ~r_ack;
  assign bus.bus_data_out = r_rdata;
  // a simultaneous read and write is treated as a write
  assign w_frame = {bus.bus_write ? SPI_CMD_WRITE : SPI_CMD_READ,
                    (8 * ADDR_BYTES)'(bus.bus_address_in),
                    bus.bus_write ? bus.bus_data_in : 8'h00};
`ifdef SPI_RESP_CACHE_EN
  logic        r_cv;
  logic [15:0] r_ca;
  logic [7:0]  r_cd;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  assign w_hit = ~bus.bus_write & r_cv & (r_ca == bus.bus_address_in);
`else
  assign w_hit = 1'b0;
`endif
  assign w_start = (r_state == ST_IDLE) & w_req & ~w_hit;
  spi_mem_responder_bit_engine #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) u_engine (
    .clk(clk), .rst(rst), .i_start(w_start), .i_tx(w_frame), .i_miso(spi_miso),
    .o_sck(spi_sck), .o_mosi(spi_mosi), .o_done(w_done), .o_rx(w_rx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      spi_cs_n <= 1'b1;
      r_ack    <= 1'b0;
      r_wr     <= 1'b0;
      r_rdata  <= 8'h00;
`ifdef SPI_RESP_CACHE_EN
      r_cv     <= 1'b0;
      r_ca     <= '0;
      r_cd     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_wr <= bus.bus_write;
`ifdef SPI_RESP_CACHE_EN
          r_addr  <= bus.bus_address_in;
          r_wdata <= bus.bus_data_in;
          if (w_hit) begin
            r_state <= ST_DONE;
            r_ack   <= 1'b1;
            r_rdata <= r_cd;
          end else
`endif
          begin
            r_state  <= ST_SHIFT;
            spi_cs_n <= 1'b0;
          end
        end
        ST_SHIFT: if (w_done) begin
          r_state  <= ST_DONE;
          spi_cs_n <= 1'b1;
          r_ack    <= 1'b1;
          if (!r_wr) r_rdata <= w_rx;
`ifdef SPI_RESP_CACHE_EN
          if (!r_wr) begin
            r_cv <= 1'b1;
            r_ca <= r_addr;
            r_cd <= w_rx;
          end else if (r_cv && r_ca == r_addr) r_cd <= r_wdata;
`endif
        end
        ST_DONE: if (!w_req) begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: directed tests of the SPI memory responder against a 23LC512-style model.
module tb_spi_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  spi_mem_responder_if bif();
  spi_mem_responder_if bif1();
  logic spi_cs_n, spi_sck, spi_mosi;
  logic spi_miso = 1'b0;
  logic cs1, sck1, mosi1;
  spi_mem_responder u_dut (.clk(clk), .rst(rst), .bus(bif.slave), .spi_cs_n(spi_cs_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso));
  spi_mem_responder #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1.slave), .spi_cs_n(cs1),
    .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(1'b1));
  int total = 0;
  int bad = 0;
  // SPI SRAM model
  logic [7:0]  mem [0:65535];
  logic [31:0] sh = 0;
  logic [31:0] last_frame = 0;
  logic [7:0]  rd = 0;
  int bitc = 0;
  int frames = 0;
  always @(negedge spi_cs_n) bitc = 0;
  always @(posedge spi_cs_n) begin last_frame = sh; frames++; end
  always @(posedge spi_sck) if (!spi_cs_n) begin
    sh = {sh[30:0], spi_mosi};
    bitc++;
    if (bitc == 24 && sh[23:16] == 8'h03) rd = mem[sh[15:0]];
    if (bitc == 32 && sh[31:24] == 8'h02) mem[sh[23:8]] = sh[7:0];
  end
  always @(negedge spi_sck) if (!spi_cs_n && bitc >= 24 && bitc < 32) spi_miso = rd[7 - (bitc - 24)];
  logic [31:0] fr1 = 0;
  always @(posedge sck1) if (!cs1) fr1 = {fr1[30:0], mosi1};
  // SCK period and CS gap monitors, sampled on the falling clk edge
  int cyc = 0, last_rise = -1, per_min = 1000, per_max = 0, gap_cnt = 0, gap_min = 1000;
  int last_rise1 = -1, per1_min = 1000, per1_max = 0;
  logic p_sck = 0, p_cs = 1, p_sck1 = 0;
  always @(negedge clk) begin
    cyc++;
    if (spi_cs_n) last_rise = -1;
    else if (spi_sck && !p_sck) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (cs1) last_rise1 = -1;
    else if (sck1 && !p_sck1) begin
      if (last_rise1 >= 0) begin
        if (cyc - last_rise1 < per1_min) per1_min = cyc - last_rise1;
        if (cyc - last_rise1 > per1_max) per1_max = cyc - last_rise1;
      end
      last_rise1 = cyc;
    end
    if (!spi_cs_n && p_cs && gap_cnt < gap_min) gap_min = gap_cnt;
    gap_cnt = spi_cs_n ? gap_cnt + 1 : 0;
    p_sck = spi_sck; p_cs = spi_cs_n; p_sck1 = sck1;
  end

  task automatic bus_op(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d,
                        output int wc, output int cl);
    @(negedge clk);
    bif.bus_address_in = a; bif.bus_data_in = d; bif.bus_read = r; bif.bus_write = w;
    #1;
    wc = 0; cl = 0;
    while (bif.bus_wait && wc < 2000) begin
      wc++;
      if (!spi_cs_n) cl++;
      @(negedge clk);
    end
  endtask

  task automatic drop();
    bif.bus_read = 0; bif.bus_write = 0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1;
    @(negedge clk); @(negedge clk);
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", spi_cs_n); end
    total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
    total++; if (bif.bus_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bif.bus_data_out); end
    total++; if (bif.bus_wait !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", bif.bus_wait); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int wc, cl, f0;
    f0 = frames;
    bus_op(1, 0, 16'h1234, 8'h00, wc, cl);
    total++; if (wc !== 129) begin bad++; $display("FAIL read_wait_cycles got=%0d exp=129", wc); end
    total++; if (cl !== 128) begin bad++; $display("FAIL read_cs_low got=%0d exp=128", cl); end
    total++; if (bif.bus_data_out !== 8'hA5) begin bad++; $display("FAIL read_data got=%h exp=a5", bif.bus_data_out); end
    drop();
    total++; if (bif.bus_data_out !== 8'hA5) begin bad++; $display("FAIL read_data_held got=%h exp=a5", bif.bus_data_out); end
    total++; if (last_frame !== 32'h03123400) begin bad++; $display("FAIL read_frame got=%h exp=03123400", last_frame); end
    total++; if (frames !== f0 + 1) begin bad++; $display("FAIL read_frame_count got=%0d exp=%0d", frames, f0 + 1); end
  endtask

  task automatic test_write();
    int wc, cl;
    bus_op(0, 1, 16'h00FF, 8'h5C, wc, cl);
    total++; if (wc !== 129) begin bad++; $display("FAIL write_wait_cycles got=%0d exp=129", wc); end
    drop();
    total++; if (last_frame !== 32'h0200FF5C) begin bad++; $display("FAIL write_frame got=%h exp=0200ff5c", last_frame); end
    total++; if (bif.bus_data_out !== 8'hA5) begin bad++; $display("FAIL write_data_unchanged got=%h exp=a5", bif.bus_data_out); end
    total++; if (mem[16'h00FF] !== 8'h5C) begin bad++; $display("FAIL write_mem got=%h exp=5c", mem[16'h00FF]); end
  endtask

  task automatic test_back_to_back();
    int wc, cl;
    gap_min = 1000;
    bus_op(1, 0, 16'h00FF, 8'h00, wc, cl);
    total++; if (bif.bus_data_out !== 8'h5C) begin bad++; $display("FAIL b2b_read1 got=%h exp=5c", bif.bus_data_out); end
    drop();
    bus_op(0, 1, 16'h0200, 8'h3C, wc, cl);
    drop();
    bus_op(1, 0, 16'h0200, 8'h00, wc, cl);
    total++; if (bif.bus_data_out !== 8'h3C) begin bad++; $display("FAIL b2b_read2 got=%h exp=3c", bif.bus_data_out); end
    drop();
    total++; if (!(gap_min >= 1 && gap_min < 1000)) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp>=1", gap_min); end
    total++; if (per_min !== 4 || per_max !== 4) begin bad++; $display("FAIL b2b_sck_period got=%0d..%0d exp=4", per_min, per_max); end
  endtask

  task automatic test_clkdiv1();
    int wc;
    @(negedge clk);
    bif1.bus_address_in = 16'h1234; bif1.bus_data_in = 8'h00; bif1.bus_write = 0; bif1.bus_read = 1;
    #1;
    wc = 0;
    while (bif1.bus_wait && wc < 2000) begin wc++; @(negedge clk); end
    total++; if (wc !== 65) begin bad++; $display("FAIL div1_wait_cycles got=%0d exp=65", wc); end
    total++; if (bif1.bus_data_out !== 8'hFF) begin bad++; $display("FAIL div1_data got=%h exp=ff", bif1.bus_data_out); end
    bif1.bus_read = 0;
    @(negedge clk);
    total++; if (fr1 !== 32'h03123400) begin bad++; $display("FAIL div1_frame got=%h exp=03123400", fr1); end
    total++; if (per1_min !== 2 || per1_max !== 2) begin bad++; $display("FAIL div1_sck_period got=%0d..%0d exp=2", per1_min, per1_max); end
  endtask

  task automatic test_rst_mid();
    int wc, cl;
    @(negedge clk);
    bif.bus_address_in = 16'h1234; bif.bus_read = 1;
    wc = 0;
    while (!(bitc == 10 && spi_sck) && wc < 2000) begin @(negedge clk); wc++; end
    total++; if (wc >= 2000) begin bad++; $display("FAIL rst_mid_reach_bit10 got=timeout exp=bit10"); end
    rst = 1;
    #1;
    total++; if (spi_cs_n !== 1'b1 || spi_sck !== 1'b0) begin bad++; $display("FAIL rst_mid_pins got=cs%b sck%b exp=cs1 sck0", spi_cs_n, spi_sck); end
    bif.bus_read = 0;
    @(negedge clk);
    rst = 0;
    bus_op(1, 0, 16'h1234, 8'h00, wc, cl);
    total++; if (wc !== 129 || bif.bus_data_out !== 8'hA5) begin bad++; $display("FAIL rst_mid_recover got=%0d/%h exp=129/a5", wc, bif.bus_data_out); end
    drop();
    total++; if (last_frame !== 32'h03123400) begin bad++; $display("FAIL rst_mid_frame got=%h exp=03123400", last_frame); end
  endtask

  task automatic test_both();
    int wc, cl;
    bus_op(1, 1, 16'h0010, 8'h77, wc, cl);
    drop();
    total++; if (last_frame !== 32'h02001077) begin bad++; $display("FAIL both_frame got=%h exp=02001077", last_frame); end
    total++; if (mem[16'h0010] !== 8'h77) begin bad++; $display("FAIL both_mem got=%h exp=77", mem[16'h0010]); end
    total++; if (bif.bus_data_out !== 8'hA5) begin bad++; $display("FAIL both_data got=%h exp=a5", bif.bus_data_out); end
  endtask

  task automatic test_cache();
    int wc, cl, f0;
    bus_op(1, 0, 16'h0042, 8'h00, wc, cl);
    total++; if (wc !== 129 || bif.bus_data_out !== 8'h9A) begin bad++; $display("FAIL cache_first got=%0d/%h exp=129/9a", wc, bif.bus_data_out); end
    drop();
    f0 = frames;
    bus_op(1, 0, 16'h0042, 8'h00, wc, cl);
`ifdef SPI_RESP_CACHE_EN
    total++; if (wc !== 1 || cl !== 0) begin bad++; $display("FAIL cache_hit got=%0d/%0d exp=1/0", wc, cl); end
    total++; if (bif.bus_data_out !== 8'h9A) begin bad++; $display("FAIL cache_hit_data got=%h exp=9a", bif.bus_data_out); end
    drop();
    total++; if (frames !== f0) begin bad++; $display("FAIL cache_hit_frames got=%0d exp=%0d", frames, f0); end
    bus_op(0, 1, 16'h0042, 8'h6B, wc, cl);
    drop();
    f0 = frames;
    bus_op(1, 0, 16'h0042, 8'h00, wc, cl);
    total++; if (wc !== 1 || bif.bus_data_out !== 8'h6B) begin bad++; $display("FAIL cache_update got=%0d/%h exp=1/6b", wc, bif.bus_data_out); end
    drop();
    total++; if (frames !== f0) begin bad++; $display("FAIL cache_update_frames got=%0d exp=%0d", frames, f0); end
`else
    total++; if (wc !== 129 || cl !== 128) begin bad++; $display("FAIL nocache_reread got=%0d/%0d exp=129/128", wc, cl); end
    total++; if (bif.bus_data_out !== 8'h9A) begin bad++; $display("FAIL nocache_data got=%h exp=9a", bif.bus_data_out); end
    drop();
    total++; if (frames !== f0 + 1 || last_frame !== 32'h03004200) begin bad++; $display("FAIL nocache_frame got=%0d/%h exp=%0d/03004200", frames, last_frame, f0 + 1); end
`endif
  endtask

  initial begin
    bif.bus_address_in = 0; bif.bus_data_in = 0; bif.bus_read = 0; bif.bus_write = 0;
    bif1.bus_address_in = 0; bif1.bus_data_in = 0; bif1.bus_read = 0; bif1.bus_write = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0010] = 8'h11;
    mem[16'h0042] = 8'h9A;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_clkdiv1();
    test_rst_mid();
    test_both();
    test_cache();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
